// File: rtl/bin2qdi_rr_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bin2qdi_rr_sched : round-robin feeder for one binary-to-e1of4 QDI injector
// Revision: 1.0
// ============================================================================
module bin2qdi_rr_sched #(
    parameter  int N         = 4,
    parameter  int SETUP_CYC = 2,
    parameter  int TIMEOUT   = 1024,
    parameter  int CNT_W     = 16,
    localparam int GW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [N-1:0]     in_valid,
    input  logic [2*N-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic [1:0]       din,
    output logic             req,
    input  logic             Re,
    output logic [GW-1:0]    grant_id,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] tok_cnt
);

    localparam int            WW     = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TO_VAL = WW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        REL   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             re_meta_q, re_s_q;
    logic [GW-1:0]    ptr_q, ptr_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [1:0]       din_q, din_d;
    logic             req_q, req_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] tok_q, tok_d;
    logic [3:0]       setup_q, setup_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [WW-1:0]    wait_inc;
    logic             sel_found;
    logic [GW-1:0]    sel_idx;
    logic [GW-1:0]    scan_idx;

    // Rotating scan starting just after the last winner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            scan_idx = GW'((int'(ptr_q) + k) % N);
            if (!sel_found && in_valid[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (state_q == IDLE && sel_found) begin
            in_ready[sel_idx] = 1'b1;
        end
    end

    assign wait_inc = (wait_q == TO_VAL) ? wait_q : wait_q + WW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        din_d   = din_q;
        req_d   = req_q;
        err_d   = err_q;
        tok_d   = tok_q;
        setup_d = setup_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    din_d   = in_data[{sel_idx, 1'b0} +: 2];
                    grant_d = sel_idx;
                    ptr_d   = sel_idx;
                    setup_d = 4'(SETUP_CYC - 1);
                    wait_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (setup_q != 4'd0) begin
                    setup_d = setup_q - 4'd1;
                end else if (re_s_q) begin
                    req_d   = 1'b1;
                    wait_d  = '0;
                    state_d = REQ;
                end else begin
                    wait_d = wait_inc;
                end
            end
            REQ: begin
                if (!re_s_q) begin
                    req_d   = 1'b0;
                    wait_d  = '0;
                    state_d = REL;
                end else begin
                    wait_d = wait_inc;
                end
            end
            REL: begin
                if (re_s_q) begin
                    tok_d   = tok_q + CNT_W'(1);
                    state_d = IDLE;
                end else begin
                    wait_d = wait_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        // The handshake is never aborted; a stalled converter is only flagged.
        if (wait_d == TO_VAL) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= IDLE;
            re_meta_q <= 1'b0;
            re_s_q    <= 1'b0;
            ptr_q     <= GW'(N - 1);
            grant_q   <= '0;
            din_q     <= 2'b00;
            req_q     <= 1'b0;
            err_q     <= 1'b0;
            tok_q     <= '0;
            setup_q   <= 4'd0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            re_meta_q <= Re;
            re_s_q    <= re_meta_q;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            din_q     <= din_d;
            req_q     <= req_d;
            err_q     <= err_d;
            tok_q     <= tok_d;
            setup_q   <= setup_d;
            wait_q    <= wait_d;
        end
    end

    assign din      = din_q;
    assign req      = req_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
    assign tok_cnt  = tok_q;

endmodule
`default_nettype wire
